// File: rtl/spi_xfer_arbiter.sv
// spi_xfer_arbiter
// Round-robin scheduler that shares one SPI master transfer port between
// NREQ requesters. One request is accepted at a time. Its TX word and
// slave-select are latched and offered to the SPI path. The grant is then
// held until the SPI path reports completion or the WAIT watchdog expires.
// Finally a one-cycle response is returned to the granted requester.
// All outputs are registered except req_ready, which is a combinational
// accept strobe valid only in IDLE.

module spi_xfer_arbiter #(
    parameter int NREQ    = 4,
    parameter int DW      = 32,
    parameter int SSW     = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic                      ACLK,
    input  logic                      ARESETN,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*DW-1:0]        req_data,
    input  logic [NREQ*SSW-1:0]       req_ss,
    output logic [NREQ-1:0]           rsp_valid,
    output logic                      rsp_err,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [DW-1:0]             m_data,
    output logic [SSW-1:0]            m_ss,
    input  logic                      m_done,
    output logic                      m_abort,
    output logic                      busy,
    output logic [$clog2(NREQ)-1:0]   grant_id
);

    // Index width, one extra bit for the modulo-NREQ wrap, and the watchdog width.
    localparam int IW  = $clog2(NREQ);
    localparam int IW1 = IW + 1;
    localparam int CW  = $clog2(TIMEOUT);

    localparam logic [IW1-1:0] NREQ_W   = IW1'(NREQ);
    localparam logic [IW-1:0]  LAST_ID  = IW'(NREQ - 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    // Round-robin starting point for the next search.
    logic [IW-1:0]  rr_ptr;

    // WAIT-phase watchdog counter.
    logic [CW-1:0]  cnt;

    // Result of the round-robin search.
    logic [IW1-1:0] cand;
    logic [IW-1:0]  pick;
    logic           pick_vld;
    logic [DW-1:0]  pick_data;
    logic [SSW-1:0] pick_ss;

    // Per-cycle events.
    logic           accept;
    logic           done_hit;
    logic           expire;
    logic           rsp_fire;
    logic [NREQ-1:0] rsp_hot;
    logic [IW-1:0]  rr_next;

    // Search req_valid from rr_ptr upward, wrapping modulo NREQ; first hit wins.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        cand     = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = {1'b0, rr_ptr} + IW1'(i);
            if (cand >= NREQ_W) begin
                cand = cand - NREQ_W;
            end
            if (!pick_vld && req_valid[cand[IW-1:0]]) begin
                pick     = cand[IW-1:0];
                pick_vld = 1'b1;
            end
        end
    end

    // Select the winning requester's TX word and slave-select from the packed buses.
    always_comb begin
        pick_data = '0;
        pick_ss   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick == IW'(i)) begin
                pick_data = req_data[i*DW +: DW];
                pick_ss   = req_ss[i*SSW +: SSW];
            end
        end
    end

    // Qualify the search with the FSM state to form the cycle's events.
    always_comb begin
        accept   = (state == S_IDLE) && pick_vld;
        done_hit = (state == S_WAIT) && m_done;
        // A completion in the expiry cycle takes precedence over the watchdog.
        expire   = (state == S_WAIT) && !m_done && (cnt == CNT_LAST);
        rsp_fire = done_hit || expire;
        rr_next  = (grant_id == LAST_ID) ? '0 : grant_id + IW'(1);
    end

    // One-hot accept strobe; suppressed while reset is held so nothing is taken.
    always_comb begin
        req_ready = '0;
        if (ARESETN && accept) begin
            req_ready[pick] = 1'b1;
        end
    end

    // One-hot decode of the granted requester for the response pulse.
    always_comb begin
        rsp_hot           = '0;
        rsp_hot[grant_id] = 1'b1;
    end

    // FSM state register.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (pick_vld) begin
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // No watchdog here: SPI-path backpressure may last indefinitely.
                if (m_ready) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (rsp_fire) begin
                    state_next = S_RESP;
                end
            end
            S_RESP: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Latch the accepted transfer; it stays stable until the next acceptance.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            m_data   <= '0;
            m_ss     <= '0;
            grant_id <= '0;
        end else if (accept) begin
            m_data   <= pick_data;
            m_ss     <= pick_ss;
            grant_id <= pick;
        end
    end

    // Watchdog: cleared while issuing, counts in WAIT and saturates at its last value.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            cnt <= '0;
        end else if (state == S_ISSUE) begin
            cnt <= '0;
        end else if ((state == S_WAIT) && (cnt != CNT_LAST)) begin
            cnt <= cnt + CW'(1);
        end
    end

    // Advance the round-robin pointer past the requester just served.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rr_ptr <= '0;
        end else if (state == S_RESP) begin
            rr_ptr <= rr_next;
        end
    end

    // Registered handshake and status outputs, derived from the upcoming state.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            m_valid <= 1'b0;
            busy    <= 1'b0;
        end else begin
            m_valid <= (state_next == S_ISSUE);
            busy    <= (state_next != S_IDLE);
        end
    end

    // One-cycle response and abort pulses, raised as WAIT hands over to RESP.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rsp_valid <= '0;
            rsp_err   <= 1'b0;
            m_abort   <= 1'b0;
        end else begin
            m_abort <= expire;
            if (rsp_fire) begin
                rsp_valid <= rsp_hot;
                rsp_err   <= expire;
            end else begin
                rsp_valid <= '0;
                rsp_err   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Directed testbench for spi_xfer_arbiter (NREQ=4, DW=32, SSW=2, TIMEOUT=16).
// Inputs are driven and outputs sampled 1 ns after each rising ACLK edge.

module tb_spi_xfer_arbiter;

    localparam int NREQ    = 4;
    localparam int DW      = 32;
    localparam int SSW     = 2;
    localparam int TIMEOUT = 16;

    logic                  ACLK = 1'b0;
    logic                  ARESETN;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*DW-1:0]    req_data;
    logic [NREQ*SSW-1:0]   req_ss;
    logic [NREQ-1:0]       rsp_valid;
    logic                  rsp_err;
    logic                  m_valid;
    logic                  m_ready;
    logic [DW-1:0]         m_data;
    logic [SSW-1:0]        m_ss;
    logic                  m_done;
    logic                  m_abort;
    logic                  busy;
    logic [1:0]            grant_id;

    int nvec = 0;
    int nerr = 0;

    spi_xfer_arbiter #(
        .NREQ    (NREQ),
        .DW      (DW),
        .SSW     (SSW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .ACLK      (ACLK),
        .ARESETN   (ARESETN),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_ss    (req_ss),
        .rsp_valid (rsp_valid),
        .rsp_err   (rsp_err),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_ss      (m_ss),
        .m_done    (m_done),
        .m_abort   (m_abort),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    always #5 ACLK = ~ACLK;

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic apply_reset();
        ARESETN   = 1'b0;
        req_valid = '0;
        m_done    = 1'b0;
        tick();
        tick();
        ARESETN = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        ARESETN   = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_ss    = '0;
        m_ready   = 1'b0;
        m_done    = 1'b0;
        tick();
        tick();
        nvec++; if (m_valid !== 1'b0) begin nerr++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy: got %b want 0", busy); end
        nvec++; if (m_abort !== 1'b0) begin nerr++; $display("FAIL reset_m_abort: got %b want 0", m_abort); end
        nvec++; if (rsp_valid !== 4'b0000) begin nerr++; $display("FAIL reset_rsp_valid: got %b want 0000", rsp_valid); end
        nvec++; if (rsp_err !== 1'b0) begin nerr++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
        nvec++; if (m_data !== 32'h0) begin nerr++; $display("FAIL reset_m_data: got %h want 0", m_data); end
        nvec++; if (m_ss !== 2'b00) begin nerr++; $display("FAIL reset_m_ss: got %b want 00", m_ss); end
        nvec++; if (grant_id !== 2'd0) begin nerr++; $display("FAIL reset_grant_id: got %0d want 0", grant_id); end
        ARESETN = 1'b1;
        #1;
        nvec++; if (req_ready !== 4'b0000) begin nerr++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
    endtask

    task automatic test_single();
        req_data[0 +: 32] = 32'hA5A5_0001;
        req_ss[1:0]       = 2'b01;
        req_valid         = 4'b0001;
        m_ready           = 1'b1;
        m_done            = 1'b0;
        #1;
        nvec++; if (req_ready !== 4'b0001) begin nerr++; $display("FAIL single_req_ready: got %b want 0001", req_ready); end
        tick(); // ISSUE
        nvec++; if (m_valid !== 1'b1) begin nerr++; $display("FAIL single_m_valid: got %b want 1", m_valid); end
        nvec++; if (m_data !== 32'hA5A5_0001) begin nerr++; $display("FAIL single_m_data: got %h want a5a50001", m_data); end
        nvec++; if (m_ss !== 2'b01) begin nerr++; $display("FAIL single_m_ss: got %b want 01", m_ss); end
        nvec++; if (grant_id !== 2'd0) begin nerr++; $display("FAIL single_grant_id: got %0d want 0", grant_id); end
        nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL single_busy: got %b want 1", busy); end
        req_valid         = 4'b0000;
        req_data[0 +: 32] = 32'hDEAD_BEEF;
        req_ss[1:0]       = 2'b10;
        tick(); // WAIT
        nvec++; if (m_valid !== 1'b0) begin nerr++; $display("FAIL single_m_valid_wait: got %b want 0", m_valid); end
        nvec++; if (m_data !== 32'hA5A5_0001) begin nerr++; $display("FAIL single_latched: got %h want a5a50001", m_data); end
        tick();
        nvec++; if (rsp_valid !== 4'b0000) begin nerr++; $display("FAIL single_early_rsp: got %b want 0000", rsp_valid); end
        m_done = 1'b1;
        tick(); // RESP
        m_done = 1'b0;
        nvec++; if (rsp_valid !== 4'b0001) begin nerr++; $display("FAIL single_rsp_valid: got %b want 0001", rsp_valid); end
        nvec++; if (rsp_err !== 1'b0) begin nerr++; $display("FAIL single_rsp_err: got %b want 0", rsp_err); end
        nvec++; if (m_abort !== 1'b0) begin nerr++; $display("FAIL single_m_abort: got %b want 0", m_abort); end
        tick(); // IDLE
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL single_busy_end: got %b want 0", busy); end
        nvec++; if (rsp_valid !== 4'b0000) begin nerr++; $display("FAIL single_rsp_drop: got %b want 0000", rsp_valid); end
    endtask

    task automatic test_simultaneous();
        logic [3:0] oh;
        logic [1:0] g;
        apply_reset();
        for (int i = 0; i < NREQ; i++) begin
            req_data[i*DW +: DW] = 32'h1000_0000 + i;
            req_ss[i*SSW +: SSW] = 2'(i);
        end
        req_valid = 4'b1111;
        m_ready   = 1'b1;
        m_done    = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            g  = 2'(k % 4);
            oh = 4'b0001 << g;
            nvec++; if (req_ready !== oh) begin nerr++; $display("FAIL simul_req_ready[%0d]: got %b want %b", k, req_ready, oh); end
            tick(); // ISSUE
            nvec++; if (grant_id !== g) begin nerr++; $display("FAIL simul_grant[%0d]: got %0d want %0d", k, grant_id, g); end
            nvec++; if (m_data !== 32'h1000_0000 + 32'(g)) begin nerr++; $display("FAIL simul_m_data[%0d]: got %h want %h", k, m_data, 32'h1000_0000 + 32'(g)); end
            nvec++; if (m_ss !== g) begin nerr++; $display("FAIL simul_m_ss[%0d]: got %b want %b", k, m_ss, g); end
            tick(); // WAIT
            tick(); // RESP
            nvec++; if (rsp_valid !== oh) begin nerr++; $display("FAIL simul_rsp_valid[%0d]: got %b want %b", k, rsp_valid, oh); end
            nvec++; if (rsp_err !== 1'b0) begin nerr++; $display("FAIL simul_rsp_err[%0d]: got %b want 0", k, rsp_err); end
            tick(); // IDLE
        end
    endtask

    task automatic test_fairness();
        logic [3:0] oh;
        logic [1:0] g;
        apply_reset();
        req_valid = 4'b0101;
        m_ready   = 1'b1;
        m_done    = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            g  = (k % 2 == 0) ? 2'd0 : 2'd2;
            oh = 4'b0001 << g;
            nvec++; if (req_ready !== oh) begin nerr++; $display("FAIL fair_req_ready[%0d]: got %b want %b", k, req_ready, oh); end
            nvec++; if ((req_ready & ~req_valid) !== 4'b0000) begin nerr++; $display("FAIL fair_idle_ready[%0d]: got %b want 0000", k, req_ready & ~req_valid); end
            tick(); // ISSUE
            nvec++; if (grant_id !== g) begin nerr++; $display("FAIL fair_grant[%0d]: got %0d want %0d", k, grant_id, g); end
            tick(); // WAIT
            tick(); // RESP
            nvec++; if (rsp_valid !== oh) begin nerr++; $display("FAIL fair_rsp_valid[%0d]: got %b want %b", k, rsp_valid, oh); end
            tick(); // IDLE
        end
        req_valid = 4'b0000;
        m_done    = 1'b0;
    endtask

    task automatic test_timeout();
        req_data[1*DW +: DW] = 32'h7777_0001;
        req_valid = 4'b0010;
        m_ready   = 1'b1;
        m_done    = 1'b0;
        #1;
        nvec++; if (req_ready !== 4'b0010) begin nerr++; $display("FAIL tmo_req_ready: got %b want 0010", req_ready); end
        tick(); // ISSUE
        req_valid = 4'b0000;
        tick(); // WAIT entry
        for (int c = 1; c < TIMEOUT; c++) begin
            tick();
            nvec++; if (m_abort !== 1'b0) begin nerr++; $display("FAIL tmo_early_abort[%0d]: got %b want 0", c, m_abort); end
            nvec++; if (rsp_valid !== 4'b0000) begin nerr++; $display("FAIL tmo_early_rsp[%0d]: got %b want 0000", c, rsp_valid); end
        end
        tick(); // 16 cycles after WAIT entry
        nvec++; if (m_abort !== 1'b1) begin nerr++; $display("FAIL tmo_abort: got %b want 1", m_abort); end
        nvec++; if (rsp_valid !== 4'b0010) begin nerr++; $display("FAIL tmo_rsp_valid: got %b want 0010", rsp_valid); end
        nvec++; if (rsp_err !== 1'b1) begin nerr++; $display("FAIL tmo_rsp_err: got %b want 1", rsp_err); end
        tick(); // IDLE
        nvec++; if (m_abort !== 1'b0) begin nerr++; $display("FAIL tmo_abort_pulse: got %b want 0", m_abort); end
        nvec++; if (rsp_err !== 1'b0) begin nerr++; $display("FAIL tmo_err_pulse: got %b want 0", rsp_err); end
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL tmo_busy: got %b want 0", busy); end
        // Next request runs normally; m_done held high through IDLE/ISSUE is ignored.
        req_data[3*DW +: DW] = 32'h3333_0003;
        req_ss[3*SSW +: SSW] = 2'b11;
        req_valid = 4'b1000;
        m_done    = 1'b1;
        #1;
        nvec++; if (req_ready !== 4'b1000) begin nerr++; $display("FAIL tmo_next_ready: got %b want 1000", req_ready); end
        tick(); // ISSUE
        req_valid = 4'b0000;
        nvec++; if (grant_id !== 2'd3) begin nerr++; $display("FAIL tmo_next_grant: got %0d want 3", grant_id); end
        nvec++; if (m_data !== 32'h3333_0003) begin nerr++; $display("FAIL tmo_next_data: got %h want 33330003", m_data); end
        tick(); // WAIT
        tick(); // RESP
        nvec++; if (rsp_valid !== 4'b1000) begin nerr++; $display("FAIL tmo_next_rsp: got %b want 1000", rsp_valid); end
        nvec++; if (rsp_err !== 1'b0) begin nerr++; $display("FAIL tmo_next_err: got %b want 0", rsp_err); end
        nvec++; if (m_abort !== 1'b0) begin nerr++; $display("FAIL tmo_next_abort: got %b want 0", m_abort); end
        m_done = 1'b0;
        tick(); // IDLE
    endtask

    task automatic test_backpressure();
        req_data[0 +: DW] = 32'hCAFE_0000;
        req_ss[1:0]       = 2'b10;
        req_valid         = 4'b0001;
        m_ready           = 1'b0;
        m_done            = 1'b0;
        #1;
        nvec++; if (req_ready !== 4'b0001) begin nerr++; $display("FAIL bp_req_ready: got %b want 0001", req_ready); end
        tick(); // ISSUE
        req_valid         = 4'b0000;
        req_data[0 +: DW] = 32'h0000_0000;
        for (int c = 0; c < 50; c++) begin
            m_done = c[0];
            tick();
            nvec++; if (m_valid !== 1'b1) begin nerr++; $display("FAIL bp_m_valid[%0d]: got %b want 1", c, m_valid); end
            nvec++; if (m_data !== 32'hCAFE_0000) begin nerr++; $display("FAIL bp_m_data[%0d]: got %h want cafe0000", c, m_data); end
            nvec++; if (m_abort !== 1'b0) begin nerr++; $display("FAIL bp_m_abort[%0d]: got %b want 0", c, m_abort); end
            nvec++; if (rsp_valid !== 4'b0000) begin nerr++; $display("FAIL bp_rsp_valid[%0d]: got %b want 0000", c, rsp_valid); end
        end
        m_done  = 1'b0;
        m_ready = 1'b1;
        tick(); // WAIT
        nvec++; if (m_valid !== 1'b0) begin nerr++; $display("FAIL bp_m_valid_drop: got %b want 0", m_valid); end
        m_done = 1'b1;
        tick(); // RESP
        m_done = 1'b0;
        nvec++; if (rsp_valid !== 4'b0001) begin nerr++; $display("FAIL bp_rsp_valid: got %b want 0001", rsp_valid); end
        nvec++; if (rsp_err !== 1'b0) begin nerr++; $display("FAIL bp_rsp_err: got %b want 0", rsp_err); end
        tick(); // IDLE
    endtask

    task automatic test_done_at_expiry();
        req_data[2*DW +: DW] = 32'h2222_0002;
        req_valid = 4'b0100;
        m_ready   = 1'b1;
        m_done    = 1'b0;
        #1;
        nvec++; if (req_ready !== 4'b0100) begin nerr++; $display("FAIL edge_req_ready: got %b want 0100", req_ready); end
        tick(); // ISSUE
        req_valid = 4'b0000;
        tick(); // WAIT entry
        for (int c = 1; c < TIMEOUT; c++) begin
            tick();
            nvec++; if (m_abort !== 1'b0) begin nerr++; $display("FAIL edge_early_abort[%0d]: got %b want 0", c, m_abort); end
        end
        m_done = 1'b1; // sampled in the expiry cycle
        tick();
        m_done = 1'b0;
        nvec++; if (m_abort !== 1'b0) begin nerr++; $display("FAIL edge_abort: got %b want 0", m_abort); end
        nvec++; if (rsp_valid !== 4'b0100) begin nerr++; $display("FAIL edge_rsp_valid: got %b want 0100", rsp_valid); end
        nvec++; if (rsp_err !== 1'b0) begin nerr++; $display("FAIL edge_rsp_err: got %b want 0", rsp_err); end
        tick(); // IDLE
        nvec++; if (m_abort !== 1'b0) begin nerr++; $display("FAIL edge_abort_after: got %b want 0", m_abort); end
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL edge_busy: got %b want 0", busy); end
    endtask

    task automatic test_reset_mid_wait();
        req_data[1*DW +: DW] = 32'h1111_AAAA;
        req_ss[1*SSW +: SSW] = 2'b01;
        req_valid = 4'b0010;
        m_ready   = 1'b1;
        m_done    = 1'b0;
        #1;
        nvec++; if (req_ready !== 4'b0010) begin nerr++; $display("FAIL rst_req_ready: got %b want 0010", req_ready); end
        tick(); // ISSUE
        tick(); // WAIT
        tick();
        tick();
        ARESETN   = 1'b0;
        req_valid = 4'b1010;
        #1;
        nvec++; if (m_valid !== 1'b0) begin nerr++; $display("FAIL rst_m_valid: got %b want 0", m_valid); end
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL rst_busy: got %b want 0", busy); end
        nvec++; if (grant_id !== 2'd0) begin nerr++; $display("FAIL rst_grant_id: got %0d want 0", grant_id); end
        nvec++; if (m_data !== 32'h0) begin nerr++; $display("FAIL rst_m_data: got %h want 0", m_data); end
        nvec++; if (m_ss !== 2'b00) begin nerr++; $display("FAIL rst_m_ss: got %b want 00", m_ss); end
        nvec++; if (req_ready !== 4'b0000) begin nerr++; $display("FAIL rst_req_ready_held: got %b want 0000", req_ready); end
        for (int c = 0; c < 2; c++) begin
            tick();
            nvec++; if (rsp_valid !== 4'b0000) begin nerr++; $display("FAIL rst_rsp_valid[%0d]: got %b want 0000", c, rsp_valid); end
            nvec++; if (m_abort !== 1'b0) begin nerr++; $display("FAIL rst_m_abort[%0d]: got %b want 0", c, m_abort); end
        end
        ARESETN = 1'b1;
        #1;
        nvec++; if (req_ready !== 4'b0010) begin nerr++; $display("FAIL rst_first_grant: got %b want 0010", req_ready); end
        tick(); // ISSUE
        req_valid = 4'b0000;
        nvec++; if (grant_id !== 2'd1) begin nerr++; $display("FAIL rst_grant_after: got %0d want 1", grant_id); end
        nvec++; if (m_data !== 32'h1111_AAAA) begin nerr++; $display("FAIL rst_data_after: got %h want 1111aaaa", m_data); end
        m_done = 1'b1;
        tick(); // WAIT
        tick(); // RESP
        m_done = 1'b0;
        nvec++; if (rsp_valid !== 4'b0010) begin nerr++; $display("FAIL rst_rsp_after: got %b want 0010", rsp_valid); end
        nvec++; if (rsp_err !== 1'b0) begin nerr++; $display("FAIL rst_err_after: got %b want 0", rsp_err); end
        tick(); // IDLE
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL rst_busy_end: got %b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_fairness();
        test_timeout();
        test_backpressure();
        test_done_at_expiry();
        test_reset_mid_wait();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, nerr=%0d", nerr);
        $fatal(1, "time limit");
    end

endmodule

// File: doc/spi_xfer_arbiter.md
Name: spi_xfer_arbiter

Overview:
Round-robin scheduler that shares one SPI master transfer port between NREQ independent requesters, for example several AXI-Lite slave ports or on-chip clients. It accepts one request at a time and issues it to the master side as a latched word plus slave-select. It then holds the grant until the master reports completion or a watchdog expires, and returns a per-requester response. It sits between the requesters and the TX/SS FIFO write side of the SPI path, in the ACLK domain.

Parameters:
NREQ, 4, number of requesters (2..8)
DW, 32, transfer data width
SSW, 2, slave-select field width
TIMEOUT, 1024, ACLK cycles allowed in WAIT before abort (>=2)

Ports:
ACLK  in  1  system clock, all logic on rising edge
ARESETN  in  1  asynchronous active-low reset
req_valid  in  NREQ  request pending, one bit per requester
req_ready  out  NREQ  one-hot accept strobe (combinational, IDLE only)
req_data  in  NREQ*DW  packed per-requester TX words, requester i at [i*DW +: DW]
req_ss  in  NREQ*SSW  packed per-requester slave-select
rsp_valid  out  NREQ  one-hot one-cycle completion pulse
rsp_err  out  1  qualifies rsp_valid: 1 = timed out
m_valid  out  1  transfer offered to SPI path
m_ready  in  1  SPI path accepts (FIFO not full)
m_data  out  DW  latched transfer word
m_ss  out  SSW  latched slave-select
m_done  in  1  one-cycle completion pulse from SPI path (SRESP, synchronised)
m_abort  out  1  one-cycle pulse on watchdog expiry
busy  out  1  state != IDLE
grant_id  out  $clog2(NREQ)  index of current or last grant

Behaviour:
- Reset (async assert, sync release):
  - State goes to IDLE; rr_ptr=0; grant_id=0; timeout counter=0.
  - m_valid, m_abort, rsp_valid, rsp_err, busy are all 0.
  - m_data and m_ss are 0.
- FSM has four states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Search req_valid starting at rr_ptr and wrapping modulo NREQ. The first set bit is g.
  - req_ready[g]=1 combinationally in that cycle.
  - At the clock edge, latch req_data[g] and req_ss[g] into m_data/m_ss, set grant_id=g, and go to ISSUE.
  - If no request is pending, stay in IDLE.
- ISSUE:
  - m_valid=1.
  - If m_ready is sampled high, go to WAIT and clear the counter. Otherwise hold, with m_data/m_ss stable.
  - There is no timeout in ISSUE; backpressure may be indefinite.
- WAIT:
  - The counter increments each cycle.
  - m_done=1: go to RESP with err=0.
  - counter==TIMEOUT-1 and m_done=0: pulse m_abort for one cycle and go to RESP with err=1.
  - If m_done and expiry occur in the same cycle, done wins: err=0, no abort.
- RESP:
  - rsp_valid[grant_id]=1 and rsp_err=err for exactly one cycle.
  - rr_ptr = (grant_id+1) mod NREQ, then return to IDLE.
- Latency:
  - req accept edge to m_valid high: 1 cycle.
  - m_done to rsp_valid: 1 cycle.
  - rsp_valid to next req_ready: 1 cycle. Minimum 4 cycles per transfer with m_ready=1 and immediate m_done.
- m_done is ignored outside WAIT; a stray pulse has no effect.
- Requester changes:
  - Changes to req_valid, req_data or req_ss after acceptance do not affect the latched transfer.
  - A requester dropping req_valid in IDLE before acceptance is simply skipped.
- Fairness:
  - A continuously requesting client cannot be granted twice while another client is pending.
  - Worst-case wait is NREQ-1 transfers.
- ARESETN assertion mid-transfer (any state): immediate return to reset values. The aborted requester receives no rsp_valid. No m_abort is generated.
- Outputs are registered except req_ready.
- Counter width is $clog2(TIMEOUT); the counter saturates and never wraps.

Test Plan:
- Single request: req_valid=4'b0001, data 0xA5A5_0001, ss=2'b01, m_ready=1, m_done 3 cycles after m_valid -> m_data=0xA5A5_0001, m_ss=01, rsp_valid=4'b0001 with rsp_err=0, busy low after RESP.
- Simultaneous requests: req_valid=4'b1111 held, immediate m_ready/m_done -> grant order 0,1,2,3,0; grant_id sequence matches; each rsp_valid one-hot.
- Fairness: req0 and req2 continuously valid -> grants alternate 0,2,0,2; req1/req3 never granted; req_ready never high for a non-requesting index.
- Timeout: TIMEOUT=16, m_done never asserted -> m_abort pulses exactly 16 cycles after WAIT entry; rsp_err=1 on the same requester; next request proceeds normally.
- Boundary: TIMEOUT=16 with m_done exactly in the expiry cycle -> rsp_err=0 and no m_abort. Also hold m_ready=0 for 50 cycles in ISSUE -> no abort, m_data stable, transfer completes once m_ready rises.
- Reset mid-WAIT: drop ARESETN for 2 cycles during WAIT of grant 1 -> all outputs 0 immediately, no rsp_valid for requester 1; after release, pending req1 is granted first because rr_ptr=0 and req0 is idle.
